// File: rtl/np_pkg.sv
// Shared definitions for the np processor and its memory-side responder.
package np_pkg;

   // Core datapath and address widths
   localparam int WIDTH    = 32;
   localparam int ADDRSIZE = 12;

   // Width of the responder wait-state counter (WAIT_CYCLES is 0..15)
   localparam int WAITW = 4;

   // Instruction opcodes shared with the core
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_JUMP  = 4'h7;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // Condition codes used by OP_JUMP
   localparam logic [2:0] CC_ALWAYS = 3'd0;
   localparam logic [2:0] CC_ZERO   = 3'd1;
   localparam logic [2:0] CC_NZERO  = 3'd2;
   localparam logic [2:0] CC_NEG    = 3'd3;
   localparam logic [2:0] CC_POS    = 3'd4;

   // Responder state encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_DONE   = 2'd2,
      ST_HALTED = 2'd3
   } resp_state_t;

endpackage

// File: rtl/np_mem_responder_if.sv
// Core <-> memory request/acknowledge bus.
interface np_mem_responder_if #(
   parameter int WIDTH    = np_pkg::WIDTH,
   parameter int ADDRSIZE = np_pkg::ADDRSIZE
);
   logic                cpu_req;
   logic                cpu_wr;
   logic [ADDRSIZE-1:0] cpu_addr;
   logic [WIDTH-1:0]    cpu_wdata;
   logic [WIDTH-1:0]    cpu_rdata;
   logic                cpu_ack;

   // Core side: issues requests, receives data and completion
   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack
   );

   // Memory side: serves requests
   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack
   );
endinterface

// File: rtl/np_mem_array.sv
// Single-port synchronous RAM with a registered, read-enabled output.
// The output register is cleared by reset so the core sees zero read data
// until the first read completes; the array contents are never reset.
module np_mem_array #(
   parameter int WIDTH    = np_pkg::WIDTH,
   parameter int ADDRSIZE = np_pkg::ADDRSIZE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic                re,
   input  logic [ADDRSIZE-1:0] addr,
   input  logic [WIDTH-1:0]    wdata,
   output logic [WIDTH-1:0]    rdata
);

   logic [WIDTH-1:0] mem [2**ADDRSIZE];
   logic [WIDTH-1:0] rdata_q;

   // Write port: one word per enabled edge
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end

   // Read register: updates only on an enabled read, holds otherwise
   always_ff @(posedge clk) begin
      if (reset)
         rdata_q <= '0;
      else if (re)
         rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/np_mem_responder.sv
// Memory-side responder for the np core: accepts one request at a time,
// inserts WAIT_CYCLES wait states, performs the access and pulses cpu_ack.
// A loader port fills the array while the core is in reset or halted.
module np_mem_responder #(
   parameter int WIDTH       = np_pkg::WIDTH,
   parameter int ADDRSIZE    = np_pkg::ADDRSIZE,
   parameter int WAIT_CYCLES = 1,
   parameter int CNTW        = 16
) (
   input  logic                clk,
   input  logic                reset,
   np_mem_responder_if.slave   bus,
   input  logic                cpu_halt,
   output logic                halted,
   input  logic                ld_we,
   input  logic [ADDRSIZE-1:0] ld_addr,
   input  logic [WIDTH-1:0]    ld_data,
   output logic                ld_err,
   output logic [CNTW-1:0]     rd_cnt,
   output logic [CNTW-1:0]     wr_cnt
);

   import np_pkg::*;

   resp_state_t         state_q, state_d;
   logic [WAITW-1:0]    cnt_q, cnt_d;
   logic                halt_seen_q, halt_seen_d;
   logic                accept;
   logic                fire;
   logic                cpu_go;

   logic                lat_wr;
   logic [ADDRSIZE-1:0] lat_addr;
   logic [WIDTH-1:0]    lat_wdata;

   logic                ack_q;
   logic                ld_err_q;
   logic [CNTW-1:0]     rd_cnt_q, wr_cnt_q;

   logic                ld_acc;
   logic                mem_we, mem_re;
   logic [ADDRSIZE-1:0] mem_addr;
   logic [WIDTH-1:0]    mem_wdata;
   logic [WIDTH-1:0]    mem_rdata;

   // FSM state, wait counter and remembered halt
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         halt_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         halt_seen_q <= halt_seen_d;
      end
   end

   // Next-state logic: halt wins over a request in IDLE, an in-flight
   // access always completes, and a halt seen meanwhile is honoured in DONE
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      halt_seen_d = halt_seen_q;
      accept      = 1'b0;
      fire        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            halt_seen_d = 1'b0;
            if (cpu_halt) begin
               state_d = ST_HALTED;
            end else if (bus.cpu_req) begin
               accept  = 1'b1;
               cnt_d   = WAITW'(WAIT_CYCLES);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            halt_seen_d = halt_seen_q | cpu_halt;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               fire    = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            halt_seen_d = 1'b0;
            state_d     = (cpu_halt || halt_seen_q) ? ST_HALTED : ST_IDLE;
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // An access completing on a reset edge is aborted
   assign cpu_go = fire & ~reset;

   // Request capture: the core may drop cpu_req after the accept cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_wr    <= bus.cpu_wr;
         lat_addr  <= bus.cpu_addr;
         lat_wdata <= bus.cpu_wdata;
      end
   end

   // Loader is only allowed while the core cannot be using the array
   assign ld_acc = ld_we & (reset | (state_q == ST_HALTED));

   // Array port mux: loader and CPU accesses never coincide
   always_comb begin
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_we    = cpu_go & lat_wr;
      mem_re    = cpu_go & ~lat_wr;
      if (ld_acc) begin
         mem_addr  = ld_addr;
         mem_wdata = ld_data;
         mem_we    = 1'b1;
         mem_re    = 1'b0;
      end
   end

   np_mem_array #(
      .WIDTH    (WIDTH),
      .ADDRSIZE (ADDRSIZE)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // Completion pulse, loader rejection pulse and saturating access counters
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q    <= 1'b0;
         ld_err_q <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         ack_q    <= fire;
         ld_err_q <= ld_we & ~ld_acc;
         if (fire && lat_wr && (wr_cnt_q != '1))
            wr_cnt_q <= wr_cnt_q + 1'b1;
         if (fire && !lat_wr && (rd_cnt_q != '1))
            rd_cnt_q <= rd_cnt_q + 1'b1;
      end
   end

   assign bus.cpu_ack   = ack_q;
   assign bus.cpu_rdata = mem_rdata;
   assign halted        = (state_q == ST_HALTED);
   assign ld_err        = ld_err_q;
   assign rd_cnt        = rd_cnt_q;
   assign wr_cnt        = wr_cnt_q;

endmodule

// File: tb/tb_np_mem_responder.sv
// Directed bench for np_mem_responder: two instances, one with no wait
// states and 16-bit counters, one with one wait state and 2-bit counters.
module tb_np_mem_responder;

   localparam int W = 32;
   localparam int A = 12;

   logic clk;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Instance 0: WAIT_CYCLES=0, CNTW=16
   logic          rst0, halt0, halted0, ld_we0, ld_err0;
   logic [A-1:0]  ld_addr0;
   logic [W-1:0]  ld_data0;
   logic [15:0]   rd_cnt0, wr_cnt0;
   np_mem_responder_if #(.WIDTH(W), .ADDRSIZE(A)) b0 ();

   // Instance 1: WAIT_CYCLES=1, CNTW=2
   logic          rst1, halt1, halted1, ld_we1, ld_err1;
   logic [A-1:0]  ld_addr1;
   logic [W-1:0]  ld_data1;
   logic [1:0]    rd_cnt1, wr_cnt1;
   np_mem_responder_if #(.WIDTH(W), .ADDRSIZE(A)) b1 ();

   np_mem_responder #(.WIDTH(W), .ADDRSIZE(A), .WAIT_CYCLES(0), .CNTW(16)) dut0 (
      .clk(clk), .reset(rst0), .bus(b0), .cpu_halt(halt0), .halted(halted0),
      .ld_we(ld_we0), .ld_addr(ld_addr0), .ld_data(ld_data0), .ld_err(ld_err0),
      .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
   );

   np_mem_responder #(.WIDTH(W), .ADDRSIZE(A), .WAIT_CYCLES(1), .CNTW(2)) dut1 (
      .clk(clk), .reset(rst1), .bus(b1), .cpu_halt(halt1), .halted(halted1),
      .ld_we(ld_we1), .ld_addr(ld_addr1), .ld_data(ld_data1), .ld_err(ld_err1),
      .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Issue one request on instance 0 and watch 8 cycles for its ack
   task automatic access0(input logic wr, input logic [A-1:0] a, input logic [W-1:0] d,
                          output int first, output int nacks, output logic [W-1:0] rd_at_ack);
      first = -1; nacks = 0; rd_at_ack = '0;
      b0.cpu_req = 1'b1; b0.cpu_wr = wr; b0.cpu_addr = a; b0.cpu_wdata = d;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (b0.cpu_ack === 1'b1) begin
            nacks++;
            if (first < 0) begin
               first = k;
               rd_at_ack = b0.cpu_rdata;
            end
         end
         if (k == 1) b0.cpu_req = 1'b0;
      end
   endtask

   // Same for instance 1
   task automatic access1(input logic wr, input logic [A-1:0] a, input logic [W-1:0] d,
                          output int first, output int nacks, output logic [W-1:0] rd_at_ack);
      first = -1; nacks = 0; rd_at_ack = '0;
      b1.cpu_req = 1'b1; b1.cpu_wr = wr; b1.cpu_addr = a; b1.cpu_wdata = d;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (b1.cpu_ack === 1'b1) begin
            nacks++;
            if (first < 0) begin
               first = k;
               rd_at_ack = b1.cpu_rdata;
            end
         end
         if (k == 1) b1.cpu_req = 1'b0;
      end
   endtask

   task automatic test_preload_read();
      logic [5:0] ackv;
      ackv = '0;
      ld_we1 = 1'b1; ld_addr1 = 12'h005; ld_data1 = 32'h2400_5003;
      @(negedge clk);
      ld_we1 = 1'b0;
      @(negedge clk);
      n_cmp++; if (ld_err1 !== 1'b0) begin n_bad++; $display("FAIL preload_ld_err: got %b want 0", ld_err1); end
      n_cmp++; if ({b1.cpu_ack, halted1, rd_cnt1, wr_cnt1} !== 6'b0) begin n_bad++;
         $display("FAIL reset1_ctrl: got %b want 000000", {b1.cpu_ack, halted1, rd_cnt1, wr_cnt1}); end
      n_cmp++; if (b1.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset1_rdata: got %h want 0", b1.cpu_rdata); end
      rst1 = 1'b0;
      @(negedge clk);
      b1.cpu_req = 1'b1; b1.cpu_wr = 1'b0; b1.cpu_addr = 12'h005;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         ackv[k-1] = b1.cpu_ack;
         if (k == 1) b1.cpu_req = 1'b0;
         if (k == 3) begin
            n_cmp++; if (b1.cpu_rdata !== 32'h2400_5003) begin n_bad++;
               $display("FAIL preload_rdata: got %h want 24005003", b1.cpu_rdata); end
            n_cmp++; if (rd_cnt1 !== 2'd1) begin n_bad++; $display("FAIL preload_rd_cnt: got %0d want 1", rd_cnt1); end
         end
      end
      n_cmp++; if (ackv !== 6'b000100) begin n_bad++; $display("FAIL preload_ack_timing: got %b want 000100", ackv); end
   endtask

   task automatic test_saturation();
      int f, n;
      logic [W-1:0] r;
      for (int i = 0; i < 4; i++) access1(1'b0, 12'h005, '0, f, n, r);
      n_cmp++; if (rd_cnt1 !== 2'd3) begin n_bad++; $display("FAIL rd_cnt_saturate: got %0d want 3", rd_cnt1); end
      n_cmp++; if (r !== 32'h2400_5003) begin n_bad++; $display("FAIL sat_rdata: got %h want 24005003", r); end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if ({b0.cpu_ack, halted0, ld_err0} !== 3'b000) begin n_bad++;
         $display("FAIL reset0_flags: got %b want 000", {b0.cpu_ack, halted0, ld_err0}); end
      n_cmp++; if (b0.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset0_rdata: got %h want 0", b0.cpu_rdata); end
      n_cmp++; if ({rd_cnt0, wr_cnt0} !== 32'h0) begin n_bad++;
         $display("FAIL reset0_counters: got %h want 0", {rd_cnt0, wr_cnt0}); end
      rst0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int f, n;
      logic [W-1:0] r;
      access0(1'b1, 12'hFFF, 32'hDEAD_BEEF, f, n, r);
      n_cmp++; if (f !== 2 || n !== 1) begin n_bad++; $display("FAIL wr_ack_timing: got first=%0d n=%0d want 2/1", f, n); end
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL wr_rdata_unchanged: got %h want 0", r); end
      n_cmp++; if (wr_cnt0 !== 16'd1) begin n_bad++; $display("FAIL wr_cnt: got %0d want 1", wr_cnt0); end
      access0(1'b0, 12'hFFF, '0, f, n, r);
      n_cmp++; if (f !== 2 || n !== 1) begin n_bad++; $display("FAIL rd_ack_timing: got first=%0d n=%0d want 2/1", f, n); end
      n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", r); end
      n_cmp++; if (rd_cnt0 !== 16'd1) begin n_bad++; $display("FAIL rd_cnt: got %0d want 1", rd_cnt0); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] v;
      v = '0;
      b0.cpu_req = 1'b1; b0.cpu_wr = 1'b0; b0.cpu_addr = 12'hFFF;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         v[k-1] = b0.cpu_ack;
         if (k == 12) b0.cpu_req = 1'b0;
      end
      @(negedge clk);
      n_cmp++; if (v !== 12'h492) begin n_bad++; $display("FAIL b2b_ack_pattern: got %h want 492", v); end
      n_cmp++; if ((v & (v >> 1)) !== 12'h0) begin n_bad++; $display("FAIL b2b_consecutive_acks: got %b", v); end
      n_cmp++; if (rd_cnt0 !== 16'd5) begin n_bad++; $display("FAIL b2b_rd_cnt: got %0d want 5", rd_cnt0); end
      n_cmp++; if (b0.cpu_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL b2b_rdata: got %h want deadbeef", b0.cpu_rdata); end
   endtask

   task automatic test_loader_gating();
      int f, n;
      logic [W-1:0] r;
      access0(1'b1, 12'h030, 32'h1111_2222, f, n, r);
      ld_we0 = 1'b1; ld_addr0 = 12'h030; ld_data0 = 32'hCAFE_F00D;
      @(negedge clk);
      ld_we0 = 1'b0;
      n_cmp++; if (ld_err0 !== 1'b1) begin n_bad++; $display("FAIL ld_err_pulse: got %b want 1", ld_err0); end
      @(negedge clk);
      n_cmp++; if (ld_err0 !== 1'b0) begin n_bad++; $display("FAIL ld_err_clear: got %b want 0", ld_err0); end
      access0(1'b0, 12'h030, '0, f, n, r);
      n_cmp++; if (r !== 32'h1111_2222) begin n_bad++; $display("FAIL ld_rejected_data: got %h want 11112222", r); end
      n_cmp++; if (rd_cnt0 !== 16'd6 || wr_cnt0 !== 16'd2) begin n_bad++;
         $display("FAIL ld_gating_counters: got rd=%0d wr=%0d want 6/2", rd_cnt0, wr_cnt0); end
   endtask

   task automatic test_halt_busy();
      int n;
      b0.cpu_req = 1'b1; b0.cpu_wr = 1'b1; b0.cpu_addr = 12'h010; b0.cpu_wdata = 32'h1;
      @(negedge clk);
      b0.cpu_req = 1'b0; halt0 = 1'b1;
      @(negedge clk);
      n_cmp++; if (b0.cpu_ack !== 1'b1 || halted0 !== 1'b0) begin n_bad++;
         $display("FAIL halt_done_cycle: got ack=%b halted=%b want 1/0", b0.cpu_ack, halted0); end
      halt0 = 1'b0;
      @(negedge clk);
      n_cmp++; if (b0.cpu_ack !== 1'b0 || halted0 !== 1'b1) begin n_bad++;
         $display("FAIL halt_entered: got ack=%b halted=%b want 0/1", b0.cpu_ack, halted0); end
      n_cmp++; if (wr_cnt0 !== 16'd3) begin n_bad++; $display("FAIL halt_write_commit_cnt: got %0d want 3", wr_cnt0); end
      n = 0;
      b0.cpu_req = 1'b1; b0.cpu_wr = 1'b0; b0.cpu_addr = 12'h010;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (b0.cpu_ack === 1'b1) n++;
      end
      b0.cpu_req = 1'b0;
      n_cmp++; if (n !== 0 || halted0 !== 1'b1) begin n_bad++;
         $display("FAIL halted_ignores_req: got acks=%0d halted=%b want 0/1", n, halted0); end
      ld_we0 = 1'b1; ld_addr0 = 12'h030; ld_data0 = 32'hCAFE_F00D;
      @(negedge clk);
      ld_we0 = 1'b0;
      n_cmp++; if (ld_err0 !== 1'b0) begin n_bad++; $display("FAIL ld_halted_err: got %b want 0", ld_err0); end
      n_cmp++; if (b0.cpu_rdata !== 32'h1111_2222) begin n_bad++;
         $display("FAIL ld_keeps_rdata: got %h want 11112222", b0.cpu_rdata); end
   endtask

   task automatic test_reset_release_read();
      int f, n;
      logic [W-1:0] r;
      rst0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (halted0 !== 1'b0 || rd_cnt0 !== 16'd0 || wr_cnt0 !== 16'd0) begin n_bad++;
         $display("FAIL rereset_state: got halted=%b rd=%0d wr=%0d want 0/0/0", halted0, rd_cnt0, wr_cnt0); end
      rst0 = 1'b0;
      @(negedge clk);
      access0(1'b0, 12'h030, '0, f, n, r);
      n_cmp++; if (r !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL loaded_word: got %h want cafef00d", r); end
      access0(1'b0, 12'h010, '0, f, n, r);
      n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL halted_write_kept: got %h want 00000001", r); end
      n_cmp++; if (rd_cnt0 !== 16'd2) begin n_bad++; $display("FAIL rerelease_rd_cnt: got %0d want 2", rd_cnt0); end
   endtask

   task automatic test_reset_mid_busy();
      int f, n;
      logic [W-1:0] r;
      access0(1'b1, 12'h020, 32'h5555_AAAA, f, n, r);
      b0.cpu_req = 1'b1; b0.cpu_wr = 1'b1; b0.cpu_addr = 12'h020; b0.cpu_wdata = 32'h0BAD_0BAD;
      @(negedge clk);
      b0.cpu_req = 1'b0; rst0 = 1'b1;
      @(negedge clk);
      n = (b0.cpu_ack === 1'b1) ? 1 : 0;
      n_cmp++; if (rd_cnt0 !== 16'd0 || wr_cnt0 !== 16'd0) begin n_bad++;
         $display("FAIL abort_counters: got rd=%0d wr=%0d want 0/0", rd_cnt0, wr_cnt0); end
      rst0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (b0.cpu_ack === 1'b1) n++;
      end
      n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL abort_no_ack: got %0d acks want 0", n); end
      access0(1'b0, 12'h020, '0, f, n, r);
      n_cmp++; if (r !== 32'h5555_AAAA) begin n_bad++; $display("FAIL abort_no_commit: got %h want 5555aaaa", r); end
      n_cmp++; if (rd_cnt0 !== 16'd1 || wr_cnt0 !== 16'd0) begin n_bad++;
         $display("FAIL abort_after_counters: got rd=%0d wr=%0d want 1/0", rd_cnt0, wr_cnt0); end
   endtask

   initial begin
      rst0 = 1'b1; halt0 = 1'b0; ld_we0 = 1'b0; ld_addr0 = '0; ld_data0 = '0;
      b0.cpu_req = 1'b0; b0.cpu_wr = 1'b0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
      rst1 = 1'b1; halt1 = 1'b0; ld_we1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;
      b1.cpu_req = 1'b0; b1.cpu_wr = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
      @(negedge clk);
      @(negedge clk);
      test_preload_read();
      test_saturation();
      test_reset();
      test_write_read();
      test_back_to_back();
      test_loader_gating();
      test_halt_busy();
      test_reset_release_read();
      test_reset_mid_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
